// File: rtl/radix4_booth_multiplier.sv
// Sequential radix-4 (modified Booth) multiplier, signed or unsigned per operation.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/a/b/is_signed (operand
// handshake), flush (sync abort), out_valid/out_ready/product (result handshake), busy.
module radix4_booth_multiplier #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [2*N-1:0] product,
    output logic         busy
);

    // Extended width is even so the multiplier splits into whole Booth digits,
    // and at least N+1 so zero-extended unsigned operands stay non-negative.
    localparam int E  = (N % 2 == 0) ? N + 2 : N + 1;
    localparam int CW = $clog2(E / 2 + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_n;

    logic [E-1:0]  m;
    logic [E-1:0]  q;
    logic          q_1;
    logic [E+1:0]  acc;
    logic [CW-1:0] count;

    logic [E+1:0]   pp;
    logic [E+1:0]   sum;
    logic [E+1:0]   acc_n;
    logic [E-1:0]   q_n;
    logic [2*E+1:0] full;
    logic           accept;
    logic           last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign accept = in_ready && in_valid && !flush;
    assign last   = (state == CALC) && (count == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_n = CALC;
                CALC:    if (count == CW'(1)) state_n = DONE;
                DONE:    if (out_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Booth digit from {Q[1:0], q_1}; partial products sign-extended to E+2 bits.
    always_comb begin
        pp = '0;
        case ({q[1:0], q_1})
            3'b001, 3'b010: pp = {{2{m[E-1]}}, m};
            3'b011:         pp = {m[E-1], m, 1'b0};
            3'b100:         pp = -{m[E-1], m, 1'b0};
            3'b101, 3'b110: pp = -{{2{m[E-1]}}, m};
            default:        pp = '0;
        endcase
    end

    assign sum   = acc + pp;
    assign acc_n = {{2{sum[E+1]}}, sum[E+1:2]};
    assign q_n   = {sum[1:0], q[E-1:2]};
    assign full  = {acc_n, q_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                m     <= {{(E-N){a[N-1] & is_signed}}, a};
                q     <= {{(E-N){b[N-1] & is_signed}}, b};
                q_1   <= 1'b0;
                acc   <= '0;
                count <= CW'(E / 2);
            end else if (state == CALC) begin
                acc   <= acc_n;
                q     <= q_n;
                q_1   <= q[1];
                count <= count - CW'(1);
            end
            // A flushed operation never publishes its partial result.
            if (last && !flush) begin
                product <= full[2*N-1:0];
            end
        end
    end

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Directed bench for radix4_booth_multiplier: N=8 vectors, flush/reset cases,
// plus exhaustive N=4 and N=5 sweeps under random output back-pressure.
module tb_radix4_booth_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        in_valid, in_ready, is_signed, flush;
    logic        out_valid, out_ready, busy;
    logic [7:0]  a, b;
    logic [15:0] product;

    logic       v4_in, r4_in, s4, v4_out, r4_out, b4;
    logic [3:0] a4, b4_op;
    logic [7:0] p4;

    logic       v5_in, r5_in, s5, v5_out, r5_out, b5;
    logic [4:0] a5, b5_op;
    logic [9:0] p5;

    radix4_booth_multiplier #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .product(product),
        .busy(busy)
    );

    radix4_booth_multiplier #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_in), .in_ready(r4_in),
        .a(a4), .b(b4_op), .is_signed(s4), .flush(1'b0),
        .out_valid(v4_out), .out_ready(r4_out), .product(p4), .busy(b4)
    );

    radix4_booth_multiplier #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5_in), .in_ready(r5_in),
        .a(a5), .b(b5_op), .is_signed(s5), .flush(1'b0),
        .out_valid(v5_out), .out_ready(r5_out), .product(p5), .busy(b5)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge right after the accept edge.
    task automatic wait_done8(input logic [15:0] exp, input string tag);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, 5);
        chk({tag, " product"}, {16'h0, product}, {16'h0, exp});
        @(negedge clk);
        chk({tag, " out_valid drop"}, {31'h0, out_valid}, 0);
        chk({tag, " in_ready back"}, {31'h0, in_ready}, 1);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic s, input logic [15:0] exp,
                       input string tag);
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 8'h5A; b = 8'hC3; is_signed = ~s;
        wait_done8(exp, tag);
    endtask

    task automatic sweep4();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    int ea, eb, n;
                    logic [7:0] exp, prev;
                    bit seen, done;
                    ea = (s == 1 && i >= 8) ? i - 16 : i;
                    eb = (s == 1 && j >= 8) ? j - 16 : j;
                    exp = 8'((ea * eb) & 32'hFF);
                    a4 = 4'(i); b4_op = 4'(j); s4 = s[0];
                    v4_in = 1'b1; r4_out = 1'b0;
                    @(negedge clk);
                    v4_in = 1'b0;
                    seen = 0; done = 0; n = 0; prev = '0;
                    while (!done && n < 40) begin
                        @(negedge clk);
                        n++;
                        if (v4_out) begin
                            if (seen) chk("n4 hold", {24'h0, p4}, {24'h0, prev});
                            chk("n4 product", {24'h0, p4}, {24'h0, exp});
                            prev = p4; seen = 1;
                            r4_out = 1'($urandom_range(0, 1));
                            if (r4_out) begin
                                @(negedge clk);
                                r4_out = 1'b0;
                                done = 1;
                            end
                        end
                    end
                    if (!done) chk("n4 timeout", 0, 1);
                end
    endtask

    task automatic sweep5();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                for (int j = 0; j < 32; j++) begin
                    int ea, eb, n;
                    logic [9:0] exp, prev;
                    bit seen, done;
                    ea = (s == 1 && i >= 16) ? i - 32 : i;
                    eb = (s == 1 && j >= 16) ? j - 32 : j;
                    exp = 10'((ea * eb) & 32'h3FF);
                    a5 = 5'(i); b5_op = 5'(j); s5 = s[0];
                    v5_in = 1'b1; r5_out = 1'b0;
                    @(negedge clk);
                    v5_in = 1'b0;
                    seen = 0; done = 0; n = 0; prev = '0;
                    while (!done && n < 40) begin
                        @(negedge clk);
                        n++;
                        if (v5_out) begin
                            if (seen) chk("n5 hold", {22'h0, p5}, {22'h0, prev});
                            chk("n5 product", {22'h0, p5}, {22'h0, exp});
                            prev = p5; seen = 1;
                            r5_out = 1'($urandom_range(0, 1));
                            if (r5_out) begin
                                @(negedge clk);
                                r5_out = 1'b0;
                                done = 1;
                            end
                        end
                    end
                    if (!done) chk("n5 timeout", 0, 1);
                end
    endtask

    initial begin
        bit rose;
        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; is_signed = 0; flush = 0; out_ready = 1;
        v4_in = 0; a4 = 0; b4_op = 0; s4 = 0; r4_out = 0;
        v5_in = 0; a5 = 0; b5_op = 0; s5 = 0; r5_out = 0;
        #2;
        chk("rst in_ready", {31'h0, in_ready}, 1);
        chk("rst out_valid", {31'h0, out_valid}, 0);
        chk("rst busy", {31'h0, busy}, 0);
        chk("rst product", {16'h0, product}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op8(8'h80, 8'h80, 1'b1, 16'h4000, "mn*mn");
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uff*ff");
        op8(8'hFF, 8'h7F, 1'b1, 16'hFF81, "s-1*127");
        op8(8'h05, 8'hFB, 1'b0, 16'h04E7, "u5*251");

        // Flush in the 3rd CALC cycle.
        a = 8'd9; b = 8'd9; is_signed = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush in_ready", {31'h0, in_ready}, 1);
        chk("flush busy", {31'h0, busy}, 0);
        chk("flush product kept", {16'h0, product}, 32'h04E7);
        rose = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) rose = 1;
        end
        chk("flush no out_valid", {31'h0, rose}, 0);
        op8(8'h03, 8'hFB, 1'b1, 16'hFFF1, "3*-5");

        // in_valid together with flush in IDLE is refused.
        a = 8'd4; b = 8'd4; in_valid = 1; flush = 1;
        @(negedge clk);
        chk("vflush in_ready", {31'h0, in_ready}, 1);
        chk("vflush busy", {31'h0, busy}, 0);
        flush = 0; in_valid = 0;
        @(negedge clk);

        // in_valid held during CALC is ignored, then accepted once IDLE.
        a = 8'd2; b = 8'd3; is_signed = 0; in_valid = 1;
        @(negedge clk);
        a = 8'd7; b = 8'd7;
        wait_done8(16'd6, "2*3 held");
        @(negedge clk);
        in_valid = 0;
        chk("held accept busy", {31'h0, busy}, 1);
        wait_done8(16'd49, "7*7");

        // Asynchronous reset in the middle of CALC.
        a = 8'd100; b = 8'd100; in_valid = 1;
        @(negedge clk);
        a = 8'd3; b = 8'd3;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst in_ready", {31'h0, in_ready}, 1);
        chk("arst busy", {31'h0, busy}, 0);
        chk("arst product", {16'h0, product}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 0;
        wait_done8(16'd9, "post-reset 3*3");

        sweep4();
        sweep5();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
